sample_window_buffer: RTL

- Upstream feeder for the 8-input weighted combiner (Y0..Y7, 28-bit two's complement).
- Accepts a serial stream of 28-bit samples over a valid/ready handshake and assembles 8-sample windows.
- Presents each window in parallel with an out_valid/out_ready handshake.
- Two modes: block (non-overlapping windows) and sliding (stride 1, 7-sample overlap).

---
 rtl/sample_window_buffer.sv | 115 +++++++++++
 1 files changed

// File: rtl/sample_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sample_window_buffer
// Description : Collects a serial valid/ready stream of DATA_W-bit samples
//               into 8-sample windows for the 8-input weighted combiner.
//               Block mode emits non-overlapping windows. Sliding mode emits
//               one window per new sample (stride 1, 7-sample overlap).
//
// Ports       : clk, rst          rising-edge clock, synchronous active-high
//                                 reset
//               in_valid/in_ready/in_data  sample input handshake
//               slide             0 = block, 1 = sliding; used at a consume
//               flush             synchronous discard of the current window
//               Y0..Y7            window, Y0 newest, Y7 oldest
//               out_valid/out_ready        window output handshake
//               fill              number of samples held (0..8)
//               win_cnt           windows delivered, wraps at 2^CNT_W
//
// Revision    : 1.0  initial release
// ============================================================================
module sample_window_buffer #(
    parameter int DATA_W = 28,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              slide,
    input  logic              flush,
    output logic [DATA_W-1:0] Y0,
    output logic [DATA_W-1:0] Y1,
    output logic [DATA_W-1:0] Y2,
    output logic [DATA_W-1:0] Y3,
    output logic [DATA_W-1:0] Y4,
    output logic [DATA_W-1:0] Y5,
    output logic [DATA_W-1:0] Y6,
    output logic [DATA_W-1:0] Y7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        fill,
    output logic [CNT_W-1:0]  win_cnt
);

    localparam logic [3:0]       c_WIN_LEN   = 4'd8;
    localparam logic [3:0]       c_SLIDE_KEEP = 4'd7;
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_s [0:7];
    logic [3:0]        r_fill;
    logic [CNT_W-1:0]  r_win_cnt;

    logic w_full;
    logic w_accept;
    logic w_consume;

    assign w_full    = (r_fill == c_WIN_LEN);
    // A full buffer can still take a sample in the same cycle the consumer
    // drains it; this makes in_ready combinational on out_ready.
    assign in_ready  = !rst && (!w_full || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = w_full && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                r_s[k] <= '0;
            end
            r_fill    <= '0;
            r_win_cnt <= '0;
        end else if (flush) begin
            // Any accept or consume in this cycle is discarded as well.
            for (int k = 0; k < 8; k++) begin
                r_s[k] <= '0;
            end
            r_fill <= '0;
        end else begin
            if (w_accept) begin
                r_s[0] <= in_data;
                for (int k = 1; k < 8; k++) begin
                    r_s[k] <= r_s[k-1];
                end
            end

            if (w_consume) begin
                r_win_cnt <= r_win_cnt + c_CNT_ONE;
            end

            // Sliding mode keeps 7 samples after a consume so the next
            // accepted sample completes the following window.
            case ({w_accept, w_consume})
                2'b10:   r_fill <= r_fill + 4'd1;
                2'b01:   r_fill <= slide ? c_SLIDE_KEEP : 4'd0;
                2'b11:   r_fill <= slide ? c_WIN_LEN : 4'd1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign out_valid = w_full;
    assign fill      = r_fill;
    assign win_cnt   = r_win_cnt;

    assign Y0 = r_s[0];
    assign Y1 = r_s[1];
    assign Y2 = r_s[2];
    assign Y3 = r_s[3];
    assign Y4 = r_s[4];
    assign Y5 = r_s[5];
    assign Y6 = r_s[6];
    assign Y7 = r_s[7];

endmodule
`default_nettype wire
